// File: rtl/mi3_pio_pkg.sv
// mi3_pio_pkg: constants shared by the PIO blocks on the system bus.
//   - Register addresses for the input PIO register map.
//   - EDGE_TYPE encodings selecting the edge-capture polarity.
package mi3_pio_pkg;

  // Register map (word addresses on the 2-bit slave address bus)
  localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
  localparam logic [1:0] PIO_ADDR_RSVD    = 2'd1;
  localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] PIO_ADDR_EDGECAP = 2'd3;

  // Edge-capture polarity
  localparam int unsigned EDGE_RISE = 0;
  localparam int unsigned EDGE_FALL = 1;
  localparam int unsigned EDGE_ANY  = 2;

endpackage

// File: rtl/mi3_sync_edge.sv
// mi3_sync_edge: per-bit synchronizer and edge detector for the input PIO.
//   clk, reset_n : system clock, asynchronous active-low reset
//   in_port      : asynchronous external inputs
//   sync_o       : in_port after SYNC_STAGES flops
//   edge_o       : one-cycle edge pulse per bit, polarity chosen by EDGE_TYPE
// SYNC_STAGES must be in 2..4.
module mi3_sync_edge
  import mi3_pio_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned EDGE_TYPE   = EDGE_RISE
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] sync_o,
  output logic [WIDTH-1:0] edge_o
);

  // stage_q[0] is the metastability-catching flop, stage_q[SYNC_STAGES-1] the output
  logic [SYNC_STAGES-1:0][WIDTH-1:0] stage_q, stage_d;
  logic [WIDTH-1:0]                  prev_q, prev_d;

  always_comb begin
    stage_d = {stage_q[SYNC_STAGES-2:0], in_port};
    prev_d  = stage_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stage_q <= '0;
      prev_q  <= '0;
    end else begin
      stage_q <= stage_d;
      prev_q  <= prev_d;
    end
  end

  assign sync_o = stage_q[SYNC_STAGES-1];

  always_comb begin
    case (EDGE_TYPE)
      EDGE_FALL: edge_o = ~sync_o & prev_q;
      EDGE_ANY:  edge_o = sync_o ^ prev_q;
      default:   edge_o = sync_o & ~prev_q;
    endcase
  end

endmodule

// File: rtl/mi3_pio_in.sv
// mi3_pio_in: Avalon-MM input PIO with sticky edge capture and level interrupt.
//   clk, reset_n         : system clock, asynchronous active-low reset
//   address, chipselect  : register select / slave select
//   write_n, writedata   : active-low write strobe and write data
//   in_port              : asynchronous external inputs (WIDTH bits)
//   readdata             : registered read data, one cycle latency, upper bits zero
//   irq                  : |(edgecap & irqmask), driven only from flops
// Registers: 0 DATA (ro), 1 reserved, 2 IRQMASK (rw), 3 EDGECAP (read, write-1-to-clear).
module mi3_pio_in
  import mi3_pio_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned EDGE_TYPE   = EDGE_RISE,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] sync_val;
  logic [WIDTH-1:0] edge_det;

  mi3_sync_edge #(
    .WIDTH      (WIDTH),
    .SYNC_STAGES(SYNC_STAGES),
    .EDGE_TYPE  (EDGE_TYPE)
  ) u_sync_edge (
    .clk    (clk),
    .reset_n(reset_n),
    .in_port(in_port),
    .sync_o (sync_val),
    .edge_o (edge_det)
  );

  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic [WIDTH-1:0] irqmask_q, irqmask_d;
  logic [31:0]      readdata_q, readdata_d;
  logic             wr_en;
  logic [WIDTH-1:0] clr;
  logic [31:0]      rd_word;

  always_comb begin
    wr_en = chipselect & ~write_n;
    clr   = (wr_en && (address == PIO_ADDR_EDGECAP)) ? writedata[WIDTH-1:0] : '0;

    // A new edge is ORed in after the clear so it survives a simultaneous W1C.
    edgecap_d = (edgecap_q & ~clr) | edge_det;

    irqmask_d = irqmask_q;
    if (wr_en && (address == PIO_ADDR_IRQMASK)) begin
      irqmask_d = writedata[WIDTH-1:0];
    end
  end

  always_comb begin
    rd_word = '0;
    case (address)
      PIO_ADDR_DATA:    rd_word[WIDTH-1:0] = sync_val;
      PIO_ADDR_RSVD:    rd_word            = '0;
      PIO_ADDR_IRQMASK: rd_word[WIDTH-1:0] = irqmask_q;
      PIO_ADDR_EDGECAP: rd_word[WIDTH-1:0] = edgecap_q;
      default:          rd_word            = '0;
    endcase
    readdata_d = chipselect ? rd_word : readdata_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edgecap_q  <= '0;
      irqmask_q  <= '0;
      readdata_q <= '0;
    end else begin
      edgecap_q  <= edgecap_d;
      irqmask_q  <= irqmask_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(edgecap_q & irqmask_q);

endmodule

// File: tb/tb_mi3_pio_in.sv
module tb_mi3_pio_in;
  import mi3_pio_pkg::*;

  localparam int unsigned W   = 32;
  localparam int unsigned S   = 2;
  localparam int          S_I = S;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'h0;
  logic [31:0] in_port = 32'h0;
  logic [31:0] rd_rise, rd_any;
  logic        irq_rise, irq_any;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mi3_pio_in #(.WIDTH(W), .EDGE_TYPE(EDGE_RISE), .SYNC_STAGES(S)) u_rise (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd_rise), .irq(irq_rise)
  );

  mi3_pio_in #(.WIDTH(W), .EDGE_TYPE(EDGE_ANY), .SYNC_STAGES(S)) u_any (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd_any), .irq(irq_any)
  );

  // Reference model: keeps a log of in_port as sampled on each clock since reset.
  // DATA is the input seen S clocks ago; an edge compares that with one clock earlier.
  logic [31:0] in_log [64];
  int          cyc;
  logic [31:0] m_cap_rise, m_cap_any, m_mask, m_rd_rise, m_rd_any;
  logic        m_irq_rise, m_irq_any;

  function automatic logic [31:0] in_at(input int k);
    if (k < 0) return 32'h0;
    return in_log[k % 64];
  endfunction

  function automatic logic [31:0] m_sync();
    return in_at(cyc - S_I);
  endfunction

  function automatic logic [31:0] m_prev();
    return in_at(cyc - S_I - 1);
  endfunction

  function automatic logic [31:0] m_clr();
    if (chipselect && !write_n && address == 2'd3) return writedata;
    return 32'h0;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cyc        <= 0;
      m_cap_rise <= 32'h0;
      m_cap_any  <= 32'h0;
      m_mask     <= 32'h0;
      m_rd_rise  <= 32'h0;
      m_rd_any   <= 32'h0;
    end else begin
      in_log[cyc % 64] <= in_port;
      cyc              <= cyc + 1;
      m_cap_rise       <= (m_cap_rise & ~m_clr()) | (m_sync() & ~m_prev());
      m_cap_any        <= (m_cap_any & ~m_clr()) | (m_sync() ^ m_prev());
      if (chipselect && !write_n && address == 2'd2) m_mask <= writedata;
      if (chipselect) begin
        case (address)
          2'd0:    begin m_rd_rise <= m_sync();   m_rd_any <= m_sync();  end
          2'd2:    begin m_rd_rise <= m_mask;     m_rd_any <= m_mask;    end
          2'd3:    begin m_rd_rise <= m_cap_rise; m_rd_any <= m_cap_any; end
          default: begin m_rd_rise <= 32'h0;      m_rd_any <= 32'h0;     end
        endcase
      end
    end
  end

  assign m_irq_rise = |(m_cap_rise & m_mask);
  assign m_irq_any  = |(m_cap_any & m_mask);

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic bus_idle();
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 2'd0;
    writedata  = 32'h0;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
  endtask

  task automatic bus_read(input logic [1:0] a);
    chipselect = 1'b1;
    write_n    = 1'b1;
    address    = a;
    writedata  = 32'h0;
  endtask

  task automatic test_reset();
    logic [1:0] addrs [3];
    addrs   = '{2'd0, 2'd2, 2'd3};
    reset_n = 1'b0;
    in_port = 32'h0;
    bus_idle();
    #3;
    total++; if (irq_rise !== 1'b0) begin bad++; $display("FAIL reset_irq_rise got=%b exp=0", irq_rise); end
    total++; if (irq_any !== 1'b0) begin bad++; $display("FAIL reset_irq_any got=%b exp=0", irq_any); end
    total++; if (rd_rise !== 32'h0) begin bad++; $display("FAIL reset_rd_rise got=%h exp=0", rd_rise); end
    total++; if (rd_any !== 32'h0) begin bad++; $display("FAIL reset_rd_any got=%h exp=0", rd_any); end
    tick(2);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus_read(addrs[i]);
      tick(1);
      total++;
      if (rd_rise !== 32'h0 || rd_any !== 32'h0) begin
        bad++; $display("FAIL reset_read addr=%0d got=%h/%h exp=0", addrs[i], rd_rise, rd_any);
      end
    end
    bus_idle();
  endtask

  task automatic test_data_edgecap();
    in_port = 32'hA5A5_0F0F;
    tick(3);
    bus_read(2'd0);
    tick(1);
    total++; if (rd_rise !== 32'hA5A5_0F0F) begin bad++; $display("FAIL data_rise got=%h exp=a5a50f0f", rd_rise); end
    total++; if (rd_any !== 32'hA5A5_0F0F) begin bad++; $display("FAIL data_any got=%h exp=a5a50f0f", rd_any); end
    bus_read(2'd3);
    tick(1);
    total++; if (rd_rise !== 32'hA5A5_0F0F) begin bad++; $display("FAIL edgecap_rise got=%h exp=a5a50f0f", rd_rise); end
    total++; if (rd_any !== 32'hA5A5_0F0F) begin bad++; $display("FAIL edgecap_any got=%h exp=a5a50f0f", rd_any); end
    total++; if (irq_rise !== 1'b0 || irq_any !== 1'b0) begin
      bad++; $display("FAIL irq_masked got=%b/%b exp=0/0", irq_rise, irq_any);
    end
    bus_idle();
  endtask

  task automatic test_irq_timing();
    in_port = 32'h0;
    tick(S + 2);
    bus_write(2'd3, 32'hFFFF_FFFF);
    tick(1);
    bus_write(2'd2, 32'h1);
    tick(1);
    bus_idle();
    total++; if (irq_rise !== 1'b0) begin bad++; $display("FAIL irq_pre got=%b exp=0", irq_rise); end
    in_port = 32'h1;
    for (int k = 1; k <= S_I + 1; k++) begin
      tick(1);
      total++;
      if (irq_rise !== (k == S_I + 1) || irq_any !== (k == S_I + 1)) begin
        bad++; $display("FAIL irq_latency cycle=%0d got=%b/%b exp=%b", k, irq_rise, irq_any, k == S_I + 1);
      end
    end
    bus_write(2'd3, 32'h0);
    tick(1);
    bus_idle();
    total++; if (irq_rise !== 1'b1) begin bad++; $display("FAIL w1c_zero got=%b exp=1", irq_rise); end
    bus_write(2'd3, 32'h1);
    tick(1);
    bus_idle();
    total++; if (irq_rise !== 1'b0 || irq_any !== 1'b0) begin
      bad++; $display("FAIL w1c_one got=%b/%b exp=0/0", irq_rise, irq_any);
    end
  endtask

  task automatic test_clear_collision();
    in_port = 32'h0;
    tick(S + 2);
    in_port = 32'h1;
    tick(S + 2);
    in_port = 32'h0;
    tick(S + 2);
    total++; if (irq_rise !== 1'b1) begin bad++; $display("FAIL coll_pre got=%b exp=1", irq_rise); end
    in_port = 32'h1;
    tick(S);
    // The new edge is captured on the same clock as this clear.
    bus_write(2'd3, 32'h1);
    tick(1);
    bus_idle();
    total++; if (irq_rise !== 1'b1 || irq_any !== 1'b1) begin
      bad++; $display("FAIL coll_irq got=%b/%b exp=1/1", irq_rise, irq_any);
    end
    bus_read(2'd3);
    tick(1);
    bus_idle();
    total++; if (rd_rise !== 32'h1) begin bad++; $display("FAIL coll_cap_rise got=%h exp=1", rd_rise); end
    total++; if (rd_any !== 32'h1) begin bad++; $display("FAIL coll_cap_any got=%h exp=1", rd_any); end
  endtask

  task automatic test_any_edge();
    in_port = 32'h0;
    tick(S + 2);
    bus_write(2'd3, 32'hFFFF_FFFF);
    tick(1);
    bus_idle();
    in_port = 32'h80;
    tick(S + 1);
    bus_read(2'd3);
    tick(1);
    total++; if (rd_any !== 32'h80) begin bad++; $display("FAIL any_rise_cap got=%h exp=80", rd_any); end
    total++; if (rd_rise !== 32'h80) begin bad++; $display("FAIL rise_rise_cap got=%h exp=80", rd_rise); end
    bus_write(2'd3, 32'h80);
    tick(1);
    bus_idle();
    tick(10 - (S_I + 3));
    in_port = 32'h0;
    tick(S + 1);
    bus_read(2'd3);
    tick(1);
    bus_idle();
    total++; if (rd_any !== 32'h80) begin bad++; $display("FAIL any_fall_cap got=%h exp=80", rd_any); end
    total++; if (rd_rise !== 32'h0) begin bad++; $display("FAIL rise_fall_cap got=%h exp=0", rd_rise); end
    total++; if (irq_any !== 1'b0) begin bad++; $display("FAIL any_masked_irq got=%b exp=0", irq_any); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) in_port = $urandom;
      chipselect = 1'($urandom_range(0, 1));
      write_n    = ($urandom_range(0, 3) != 0);
      address    = 2'($urandom_range(0, 3));
      writedata  = ($urandom_range(0, 1) == 0) ? $urandom : (32'h1 << $urandom_range(0, 31));
      tick(1);
      total++; if (rd_rise !== m_rd_rise) begin bad++; $display("FAIL rnd_rd_rise i=%0d got=%h exp=%h", i, rd_rise, m_rd_rise); end
      total++; if (rd_any !== m_rd_any) begin bad++; $display("FAIL rnd_rd_any i=%0d got=%h exp=%h", i, rd_any, m_rd_any); end
      total++; if (irq_rise !== m_irq_rise) begin bad++; $display("FAIL rnd_irq_rise i=%0d got=%b exp=%b", i, irq_rise, m_irq_rise); end
      total++; if (irq_any !== m_irq_any) begin bad++; $display("FAIL rnd_irq_any i=%0d got=%b exp=%b", i, irq_any, m_irq_any); end
    end
    bus_idle();
  endtask

  task automatic test_async_reset();
    bus_idle();
    in_port = 32'h0;
    tick(S + 2);
    bus_write(2'd2, 32'hFF);
    tick(1);
    bus_write(2'd3, 32'hFFFF_FFFF);
    tick(1);
    bus_idle();
    in_port = 32'hFF;
    tick(S + 2);
    bus_read(2'd3);
    tick(1);
    bus_idle();
    total++; if (rd_rise !== 32'hFF || irq_rise !== 1'b1) begin
      bad++; $display("FAIL arst_pre got=%h/%b exp=ff/1", rd_rise, irq_rise);
    end
    #2;
    reset_n = 1'b0;
    #1;
    total++; if (irq_rise !== 1'b0 || irq_any !== 1'b0) begin
      bad++; $display("FAIL arst_irq got=%b/%b exp=0/0", irq_rise, irq_any);
    end
    total++; if (rd_rise !== 32'h0 || rd_any !== 32'h0) begin
      bad++; $display("FAIL arst_rd got=%h/%h exp=0/0", rd_rise, rd_any);
    end
    @(negedge clk);
    tick(1);
    reset_n = 1'b1;
    // in_port is still high, so a rising edge appears S+1 clocks after release.
    tick(S + 1);
    bus_read(2'd3);
    tick(1);
    bus_idle();
    total++; if (rd_rise !== 32'hFF) begin bad++; $display("FAIL arst_release_cap got=%h exp=ff", rd_rise); end
    total++; if (irq_rise !== 1'b0) begin bad++; $display("FAIL arst_release_irq got=%b exp=0", irq_rise); end
  endtask

  initial begin
    test_reset();
    test_data_edgecap();
    test_irq_timing();
    test_clear_collision();
    test_any_edge();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
